// File: rtl/mem_ctrl_pkg.sv
// Shared CPU package: memory-controller FSM encoding and default sizes.
package mem_ctrl_pkg;

   // Access sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } mem_state_t;

   localparam int ADDR_W_DEF      = 9;   // 512-word RAM
   localparam int WAIT_CYCLES_DEF = 2;   // RAM wait states
   localparam int CNT_W           = 4;   // wait counter covers 0..15

endpackage : mem_ctrl_pkg

// File: rtl/mem_ctrl.sv
// CPU-side memory controller: MAR register, single-access sequencer
// (IDLE -> SETUP -> WAIT x N -> DONE) and read-data register for the MDR.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              MARin,
   input  logic [31:0]       busMuxOut,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       MDRout,
   output logic [31:0]       FromRAM,
   output logic              readRAM,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic              ram_we,
   output logic              ram_re,
   input  logic [31:0]       ram_rdata
);

   mem_state_t        state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [ADDR_W-1:0] mar_reg;
   logic [31:0]       wdata_reg;
   logic [31:0]       fromram_reg;
   logic              is_read_reg;
   logic              accept;
   logic              enter_done;

   // Upper bus bits beyond the RAM address width are intentionally dropped
   logic unused_bus_bits;
   assign unused_bus_bits = ^busMuxOut[31:ADDR_W];

   // Requests are only taken while idle; read wins over a simultaneous write
   assign accept     = (state_reg == IDLE) && (read || write);
   assign enter_done = (state_next == DONE) && (state_reg != DONE);

   // Next-state and wait-counter logic
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (read || write)
               state_next = SETUP;
         end
         SETUP: begin
            cnt_next   = CNT_W'(WAIT_CYCLES);
            state_next = (WAIT_CYCLES == 0) ? DONE : WAIT;
         end
         WAIT: begin
            cnt_next = cnt_reg - 1'b1;
            // leave on the edge where the counter hits zero
            if (cnt_reg <= CNT_W'(1))
               state_next = DONE;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, address, write-data and read-data registers
   always_ff @(posedge clk) begin
      if (!clr) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         mar_reg     <= '0;
         wdata_reg   <= '0;
         fromram_reg <= '0;
         is_read_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if ((state_reg == IDLE) && MARin)
            mar_reg <= busMuxOut[ADDR_W-1:0];
         if (accept) begin
            is_read_reg <= read;
            wdata_reg   <= MDRout;
         end
         if (enter_done && is_read_reg)
            fromram_reg <= ram_rdata;
      end
   end

   // All outputs decode registered state only
   assign ram_addr  = mar_reg;
   assign ram_wdata = wdata_reg;
   assign ram_re    = (state_reg == SETUP) &&  is_read_reg;
   assign ram_we    = (state_reg == SETUP) && !is_read_reg;
   assign busy      = (state_reg != IDLE);
   assign done      = (state_reg == DONE);
   assign readRAM   = (state_reg == DONE) && is_read_reg;
   assign FromRAM   = fromram_reg;

endmodule : mem_ctrl

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, RAM word-address width (512 words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, RAM access wait states (legal range 0..15).
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port clr  in  1  reset, synchronous, active-low (clr=0 sampled at a rising clk edge resets).
REQ-005 SHALL have port MARin  in  1  load the address register from busMuxOut.
REQ-006 SHALL have port busMuxOut  in  32  CPU bus value (address source).
REQ-007 SHALL have port read  in  1  read request from control unit.
REQ-008 SHALL have port write  in  1  write request from control unit.
REQ-009 SHALL have port MDRout  in  32  write data from the MDR.
REQ-010 SHALL have port FromRAM  out  32  read data to the MDR.
REQ-011 SHALL have port readRAM  out  1  one-cycle strobe qualifying FromRAM for MDR capture.
REQ-012 SHALL have port busy  out  1  access in progress (state != IDLE).
REQ-013 SHALL have port done  out  1  one-cycle access-complete pulse (read or write).
REQ-014 SHALL have ports ram_addr  out  ADDR_W;  ram_wdata  out  32;  ram_we  out  1;  ram_re  out  1;  ram_rdata  in  32 (RAM side).

Function
REQ-015 SHALL hold a MAR register; on an edge with MARin=1 and state IDLE it loads busMuxOut[ADDR_W-1:0]; upper bits discarded; MARin outside IDLE is ignored.
REQ-016 SHALL drive ram_addr from the MAR register at all times.
REQ-017 SHALL implement FSM states IDLE, SETUP, WAIT, DONE.
REQ-018 IDLE: on an edge with read=1 or write=1, accept the request, latch op type, latch MDRout into the write-data register, go to SETUP.
REQ-019 read=1 and write=1 together in IDLE SHALL accept a read; the write is dropped.
REQ-020 MARin with read/write on the same IDLE edge SHALL make the access use the newly loaded address.
REQ-021 SETUP: exactly one cycle; ram_re=1 for reads or ram_we=1 for writes; ram_wdata = latched write data; load wait counter with WAIT_CYCLES; go to WAIT, or straight to DONE if WAIT_CYCLES=0.
REQ-022 WAIT: decrement counter each cycle; go to DONE on the edge where counter reaches 0 (WAIT occupies exactly WAIT_CYCLES cycles); ram_re/ram_we = 0.
REQ-023 DONE: one cycle; done=1; for reads FromRAM loaded from ram_rdata on the WAIT->DONE (or SETUP->DONE) edge and readRAM=1; for writes readRAM=0; then IDLE.
REQ-024 Latency: request edge to done high = WAIT_CYCLES+2 cycles; back-to-back requests SHALL be accepted no earlier than the cycle after DONE.
REQ-025 read/write asserted while busy SHALL be ignored (no queueing).
REQ-026 FromRAM SHALL hold its last read value until the next read completes or reset; writes do not alter it.
REQ-027 ram_we and ram_re SHALL never be 1 in the same cycle and each SHALL be high at most one cycle per access.

Reset
REQ-028 clr=0 at an edge SHALL force state IDLE, MAR=0, write-data=0, counter=0, FromRAM=0, and readRAM=done=busy=ram_we=ram_re=0, ram_addr=0, ram_wdata=0.
REQ-029 Reset mid-access SHALL abort it; no ram_we, ram_re, done or readRAM pulse for the aborted access after the reset edge.
REQ-030 Requests sampled on a reset edge SHALL be ignored.

Structure
REQ-031 FSM state encoding and WAIT_CYCLES/ADDR_W defaults SHALL live in the shared CPU package; all RTL in one module, no sub-modules needed.
REQ-032 All outputs SHALL be registered or decoded from registered state only; no combinational path from read/write to RAM strobes.

Verification
REQ-033 MARin with busMuxOut=0x0000_0123, then read, RAM[0x123]=0xDEADBEEF -> ram_re one cycle later, readRAM=done=1 on cycle 4 after request, FromRAM=0xDEADBEEF.
REQ-034 MARin addr 0x05, MDRout=0xA5A5_0001, write -> ram_we one cycle with ram_addr=0x05, ram_wdata=0xA5A5_0001; done pulse, readRAM=0, FromRAM unchanged.
REQ-035 read=write=1 in IDLE -> only ram_re pulses; no ram_we over the access.
REQ-036 Second read pulsed during WAIT -> ignored; exactly one done; busy low in cycle after DONE.
REQ-037 clr=0 during WAIT of a write -> all outputs 0 next cycle, no done, next read succeeds normally.
REQ-038 WAIT_CYCLES=0 and busMuxOut=0xFFFF_F1FF -> MAR=0x1FF, done 2 cycles after request.
